// File: rtl/mem_ctrl.sv
// mem_ctrl: owner of the shared 8-bit RAM/IO bus, sitting directly upstream of
// the fetcher. Splits 32-bit instruction fetches and byte/half/word data
// loads/stores into byte-serial bus transactions. Data requests win at IDLE;
// a misbranch cancels pending or active instruction work.
//
// Build option: define MEM_IO_STALL_EN to add the io_buffer_full input, which
// holds off stores to the IO window (addr[17:16] == 2'b11) while it is high.
//
// Handshake: inst_ask / data_ask are one-cycle request pulses, sampled only on
// an edge with rdy=1. inst_ready / data_ready are one-cycle completion pulses;
// the port's result (inst_data / data_rdata) is valid in that cycle and held
// until that port's next completion. rdy=0 freezes every register.
//
// FSM state is the internal signal 'state' (IDLE/INST_RD/DATA_RD/DATA_WR).
module mem_ctrl #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        has_misbranch,
    input  logic        inst_ask,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ready,
    input  logic        data_ask,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
`ifdef MEM_IO_STALL_EN
    ,
    input  logic        io_buffer_full
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INST_RD = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } state_t;

    // Edges between issuing an address and capturing its byte. Only 1 is
    // exercised; the counter arithmetic is written in terms of it.
    localparam logic [3:0] LAT = 4'(RAM_LAT);

    // Byte count of a data access; the illegal size 3 is treated as a word.
    function automatic logic [3:0] size_to_n(input logic [1:0] size);
        case (size)
            2'd0:    size_to_n = 4'd1;
            2'd1:    size_to_n = 4'd2;
            default: size_to_n = 4'd4;
        endcase
    endfunction

    state_t      state;
    state_t      state_nxt;

    // Requests captured but not yet started.
    logic        inst_pend;
    logic [31:0] inst_pend_addr;
    logic        data_pend;
    logic        data_pend_wr;
    logic [1:0]  data_pend_size;
    logic [31:0] data_pend_addr;
    logic [31:0] data_pend_wdata;

    // Request candidates as seen at this edge (fresh ask overrides pending).
    logic        inst_req;
    logic [31:0] inst_req_addr;
    logic        data_req;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_wdata;
    logic        data_blocked;
    logic        start_data;
    logic        start_inst;

    // Active access context.
    logic [31:0] act_addr;
    logic [31:0] act_addr_nxt;
    logic [31:0] act_wdata;
    logic [31:0] act_wdata_nxt;
    logic [3:0]  act_n;
    logic [3:0]  act_n_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [31:0] rbuf;
    logic [31:0] rbuf_nxt;
    logic [3:0]  rd_last;
    logic [1:0]  byte_idx;
    logic [7:0]  wr_byte;

    // Next values of the registered outputs.
    logic [31:0] mem_a_nxt;
    logic [7:0]  mem_dout_nxt;
    logic        mem_wr_nxt;
    logic        inst_ready_nxt;
    logic        data_ready_nxt;
    logic [31:0] inst_data_nxt;
    logic [31:0] data_rdata_nxt;

    // A misbranch masks both the pending fetch and a same-edge inst_ask.
    assign inst_req       = (inst_pend | inst_ask) & ~has_misbranch;
    assign inst_req_addr  = inst_ask ? inst_addr : inst_pend_addr;
    assign data_req       = data_pend | data_ask;
    assign data_req_wr    = data_ask ? data_wr    : data_pend_wr;
    assign data_req_size  = data_ask ? data_size  : data_pend_size;
    assign data_req_addr  = data_ask ? data_addr  : data_pend_addr;
    assign data_req_wdata = data_ask ? data_wdata : data_pend_wdata;

`ifdef MEM_IO_STALL_EN
    assign data_blocked = data_req_wr && (data_req_addr[17:16] == 2'b11) && io_buffer_full;
`else
    assign data_blocked = 1'b0;
`endif

    // A blocked data request still counts as data_req, so it also holds off
    // instruction fetch (strict data priority).
    assign start_data = (state == IDLE) && data_req && !data_blocked;
    assign start_inst = (state == IDLE) && !data_req && inst_req;

    // Edge index at which a read delivers its result; byte slot being captured.
    assign rd_last  = act_n + LAT;
    assign byte_idx = 2'(cnt - LAT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_data) begin
                    state_nxt = data_req_wr ? DATA_WR : DATA_RD;
                end else if (start_inst) begin
                    state_nxt = INST_RD;
                end
            end
            INST_RD: begin
                if (has_misbranch || (cnt == rd_last)) begin
                    state_nxt = IDLE;
                end
            end
            DATA_RD: begin
                if (cnt == rd_last) begin
                    state_nxt = IDLE;
                end
            end
            DATA_WR: begin
                if (cnt == act_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath decode: next values of bus, result and context regs.
    always_comb begin
        mem_a_nxt      = mem_a;
        mem_dout_nxt   = mem_dout;
        mem_wr_nxt     = 1'b0;
        inst_ready_nxt = 1'b0;
        data_ready_nxt = 1'b0;
        inst_data_nxt  = inst_data;
        data_rdata_nxt = data_rdata;
        act_addr_nxt   = act_addr;
        act_wdata_nxt  = act_wdata;
        act_n_nxt      = act_n;
        cnt_nxt        = cnt;
        rbuf_nxt       = rbuf;
        wr_byte        = 8'h00;

        case (cnt[1:0])
            2'd0:    wr_byte = act_wdata[7:0];
            2'd1:    wr_byte = act_wdata[15:8];
            2'd2:    wr_byte = act_wdata[23:16];
            default: wr_byte = act_wdata[31:24];
        endcase

        case (state)
            IDLE: begin
                if (start_data) begin
                    act_addr_nxt  = data_req_addr;
                    act_wdata_nxt = data_req_wdata;
                    act_n_nxt     = size_to_n(data_req_size);
                    cnt_nxt       = 4'd1;
                    rbuf_nxt      = 32'h0;
                    mem_a_nxt     = data_req_addr;
                    if (data_req_wr) begin
                        mem_dout_nxt = data_req_wdata[7:0];
                        mem_wr_nxt   = 1'b1;
                    end
                end else if (start_inst) begin
                    act_addr_nxt = inst_req_addr;
                    act_n_nxt    = 4'd4;
                    cnt_nxt      = 4'd1;
                    rbuf_nxt     = 32'h0;
                    mem_a_nxt    = inst_req_addr;
                end
            end
            INST_RD, DATA_RD: begin
                // A misbranch drops the fetch with mem_a left where it was.
                if (!((state == INST_RD) && has_misbranch)) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt < act_n) begin
                        mem_a_nxt = act_addr + 32'(cnt);
                    end
                    if ((cnt >= LAT) && (cnt < rd_last)) begin
                        case (byte_idx)
                            2'd0:    rbuf_nxt[7:0]   = mem_din;
                            2'd1:    rbuf_nxt[15:8]  = mem_din;
                            2'd2:    rbuf_nxt[23:16] = mem_din;
                            default: rbuf_nxt[31:24] = mem_din;
                        endcase
                    end
                    if (cnt == rd_last) begin
                        if (state == INST_RD) begin
                            inst_ready_nxt = 1'b1;
                            inst_data_nxt  = rbuf;
                        end else begin
                            data_ready_nxt = 1'b1;
                            data_rdata_nxt = rbuf;
                        end
                    end
                end
            end
            DATA_WR: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt < act_n) begin
                    mem_a_nxt    = act_addr + 32'(cnt);
                    mem_dout_nxt = wr_byte;
                    mem_wr_nxt   = 1'b1;
                end else begin
                    data_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_a      <= 32'h0;
            mem_dout   <= 8'h0;
            mem_wr     <= 1'b0;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            inst_data  <= 32'h0;
            data_rdata <= 32'h0;
            act_addr   <= 32'h0;
            act_wdata  <= 32'h0;
            act_n      <= 4'h0;
            cnt        <= 4'h0;
            rbuf       <= 32'h0;
        end else if (rdy) begin
            mem_a      <= mem_a_nxt;
            mem_dout   <= mem_dout_nxt;
            mem_wr     <= mem_wr_nxt;
            inst_ready <= inst_ready_nxt;
            data_ready <= data_ready_nxt;
            inst_data  <= inst_data_nxt;
            data_rdata <= data_rdata_nxt;
            act_addr   <= act_addr_nxt;
            act_wdata  <= act_wdata_nxt;
            act_n      <= act_n_nxt;
            cnt        <= cnt_nxt;
            rbuf       <= rbuf_nxt;
        end
    end

    // Request capture: a new ask overwrites a not-yet-started request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_pend       <= 1'b0;
            inst_pend_addr  <= 32'h0;
            data_pend       <= 1'b0;
            data_pend_wr    <= 1'b0;
            data_pend_size  <= 2'h0;
            data_pend_addr  <= 32'h0;
            data_pend_wdata <= 32'h0;
        end else if (rdy) begin
            if (has_misbranch || start_inst) begin
                inst_pend <= 1'b0;
            end else if (inst_ask) begin
                inst_pend      <= 1'b1;
                inst_pend_addr <= inst_addr;
            end

            if (start_data) begin
                data_pend <= 1'b0;
            end else if (data_ask) begin
                data_pend       <= 1'b1;
                data_pend_wr    <= data_wr;
                data_pend_size  <= data_size;
                data_pend_addr  <= data_addr;
                data_pend_wdata <= data_wdata;
            end
        end
    end

endmodule
